// File: rtl/hazard_voider_if.sv
// Purpose : bundle of the hazard voider request/response signals.
// Ports   : master drives req/hold/flush and observes the void outputs;
//           slave (the voider) is the mirror image.
//   req        N_SRC   hazard requests
//   hold       1       pipeline stall
//   flush      1       pipeline flush
//   is_void    1       squash current issue slot
//   void_src   SRC_W   source that set/extended the current window
//   remaining  CNT_W   void cycles left including the current one
//   extended   1       one-cycle pulse: active window lengthened
//   void_count STAT_W  saturating voided-cycle total
interface hazard_voider_if #(
    parameter int N_SRC  = 2,
    parameter int CNT_W  = 3,
    parameter int STAT_W = 16
);
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]  req;
    logic              hold;
    logic              flush;
    logic              is_void;
    logic [SRC_W-1:0]  void_src;
    logic [CNT_W-1:0]  remaining;
    logic              extended;
    logic [STAT_W-1:0] void_count;

    modport master (
        output req, hold, flush,
        input  is_void, void_src, remaining, extended, void_count
    );

    modport slave (
        input  req, hold, flush,
        output is_void, void_src, remaining, extended, void_count
    );
endinterface

// File: rtl/hazard_voider.sv
// Purpose : multi-source pipeline bubble generator. Each hazard source asks
//           for a void window of its own programmed length; overlapping
//           requests merge into the longest window. hold freezes the window,
//           flush cancels it. All outputs come straight from registers.
// Ports   : clk  - system clock
//           rst  - synchronous active-high reset
//           bus  - hazard_voider_if.slave (req/hold/flush in, void status out)
module hazard_voider #(
    parameter int                   N_SRC    = 2,
    parameter int                   CNT_W    = 3,
    parameter logic [N_SRC*CNT_W-1:0] VOID_LEN = {3'd2, 3'd1},
    parameter int                   STAT_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    hazard_voider_if.slave bus
);
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    generate
        if (N_SRC < 1) begin : g_bad_nsrc
            $error("hazard_voider: N_SRC must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0]  rem_q, rem_d, dec, newlen;
    logic [SRC_W-1:0]  src_q, src_d, win;
    logic              ext_q, ext_d;
    logic [STAT_W-1:0] cnt_q, cnt_d;

    // Longest requested window; strict '>' keeps the lowest index on ties
    // and makes a zero-length source never win.
    always_comb begin
        newlen = '0;
        win    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (bus.req[i] && (VOID_LEN[i*CNT_W +: CNT_W] > newlen)) begin
                newlen = VOID_LEN[i*CNT_W +: CNT_W];
                win    = SRC_W'(i);
            end
        end
    end

    always_comb begin
        rem_d = rem_q;
        src_d = src_q;
        ext_d = 1'b0;
        cnt_d = cnt_q;
        dec   = (rem_q != '0) ? rem_q - 1'b1 : '0;
        if (bus.flush) begin
            // Window cancelled; same-cycle request is dropped, source kept.
            rem_d = '0;
        end else begin
            // The slot leaving this edge was voided, held or not.
            if ((rem_q != '0) && (cnt_q != '1))
                cnt_d = cnt_q + STAT_W'(1);
            if (!bus.hold) begin
                if (newlen > dec) begin
                    rem_d = newlen;
                    src_d = win;
                    ext_d = (dec != '0);
                end else begin
                    rem_d = dec;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            src_q <= '0;
            ext_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            src_q <= src_d;
            ext_q <= ext_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.is_void    = (rem_q != '0);
    assign bus.remaining  = rem_q;
    assign bus.void_src   = src_q;
    assign bus.extended   = ext_q;
    assign bus.void_count = cnt_q;
endmodule
